// File: rtl/uart_bus_arbiter_pkg.sv
// uart_bus_arbiter_pkg: shared state encoding and UART bus direction constants
package uart_bus_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;
endpackage

// File: rtl/uart_bus_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above the pointer
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    int   k;
    logic found;
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                idx      = IW'(k);
            end
        end
    end
endmodule

// File: rtl/uart_bus_arbiter.sv
// uart_bus_arbiter: round-robin sharing of the UART register bus with setup/strobe/gap sequencing
module uart_bus_arbiter
    import uart_bus_arbiter_pkg::*;
#(
    parameter int N_REQ         = 2,
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES    = 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [3*N_REQ-1:0] req_addr_i,
    input  logic [N_REQ-1:0]   req_write_i,
    input  logic [8*N_REQ-1:0] req_wdata_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [N_REQ-1:0]   rsp_valid_o,
    output logic [7:0]         rsp_rdata_o,
    output logic               chip_sel_n_o,
    output logic [2:0]         address_o,
    output logic               read_write_o,
    output logic [7:0]         data_o,
    output logic               data_oe_o,
    input  logic [7:0]         data_i
);
    localparam int IW   = $clog2(N_REQ);
    localparam int MAXC = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    state_t          state;
    logic [IW-1:0]   ptr, owner, idx;
    logic [N_REQ-1:0] grant;
    logic [CW-1:0]   cnt;
    logic [2:0]      addr_q;
    logic            wr_q;
    logic [7:0]      wdata_q, rdata_q;
    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req   (req_valid_i),
        .ptr   (ptr),
        .grant (grant),
        .idx   (idx)
    );
    // Bus outputs decode from state so an asynchronous reset parks the bus instantly.
    always_comb begin
        req_ready_o  = (state == IDLE) ? grant : '0;
        rsp_valid_o  = (state == GAP && cnt == CW'(GAP_CYCLES - 1)) ? (N_REQ'(1) << owner) : '0;
        rsp_rdata_o  = rdata_q;
        chip_sel_n_o = (state != STROBE);
        address_o    = (state == IDLE) ? 3'd0 : addr_q;
        read_write_o = (state != IDLE && wr_q) ? WRITE : READ;
        data_oe_o    = (state != IDLE) && wr_q;
        data_o       = data_oe_o ? wdata_q : 8'd0;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            cnt     <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (|req_valid_i) begin
                    owner   <= idx;
                    addr_q  <= req_addr_i[idx*3 +: 3];
                    wr_q    <= req_write_i[idx];
                    wdata_q <= req_wdata_i[idx*8 +: 8];
                    ptr     <= (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
                    state   <= SETUP;
                end
                SETUP: begin
                    cnt   <= CW'(STROBE_CYCLES - 1);
                    state <= STROBE;
                end
                STROBE: if (cnt == '0) begin
                    if (!wr_q) rdata_q <= data_i;
                    cnt   <= CW'(GAP_CYCLES - 1);
                    state <= GAP;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                GAP: if (cnt == '0) state <= IDLE;
                     else cnt <= cnt - 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_bus_arbiter.sv
// tb_uart_bus_arbiter: directed checks of timing, arbitration, reset abort and request drop
module tb_uart_bus_arbiter;
    localparam int N = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic [N-1:0]   req_valid = '0, req_write = '0;
    logic [3*N-1:0] req_addr = '0;
    logic [8*N-1:0] req_wdata = '0;
    logic [7:0]     data_in = '0;
    logic [N-1:0]   ready, rsp_valid, ready2, rsp_valid2;
    logic [7:0]     rdata, rdata2, data_o, data_o2;
    logic           cs_n, rw, oe, cs_n2, rw2, oe2;
    logic [2:0]     addr, addr2;
    wire  [13:0]    bus = {cs_n, addr, rw, oe, data_o};
    int pass_cnt = 0, total = 0;

    uart_bus_arbiter #(.N_REQ(N), .STROBE_CYCLES(2), .GAP_CYCLES(1)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_addr_i(req_addr),
        .req_write_i(req_write), .req_wdata_i(req_wdata), .req_ready_o(ready),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rdata), .chip_sel_n_o(cs_n),
        .address_o(addr), .read_write_o(rw), .data_o(data_o), .data_oe_o(oe), .data_i(data_in)
    );
    uart_bus_arbiter #(.N_REQ(N), .STROBE_CYCLES(3), .GAP_CYCLES(2)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_addr_i(req_addr),
        .req_write_i(req_write), .req_wdata_i(req_wdata), .req_ready_o(ready2),
        .rsp_valid_o(rsp_valid2), .rsp_rdata_o(rdata2), .chip_sel_n_o(cs_n2),
        .address_o(addr2), .read_write_o(rw2), .data_o(data_o2), .data_oe_o(oe2), .data_i(data_in)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        total++; if (bus !== 14'b1_000_1_0_00000000) $display("FAIL reset_bus got=%b exp=%b", bus, 14'b1_000_1_0_00000000); else pass_cnt++;
        total++; if ({ready, rsp_valid, rdata} !== 12'h000) $display("FAIL reset_rsp got=%h exp=000", {ready, rsp_valid, rdata}); else pass_cnt++;
        idle(2);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_write();
        cyc();
        req_valid = 2'b01; req_write = 2'b01; req_addr[2:0] = 3'd3; req_wdata[7:0] = 8'hA5;
        #1;
        total++; if (ready !== 2'b01) $display("FAIL wr_ready_c0 got=%b exp=01", ready); else pass_cnt++;
        total++; if (bus !== 14'b1_000_1_0_00000000) $display("FAIL wr_bus_c0 got=%b exp=%b", bus, 14'b1_000_1_0_00000000); else pass_cnt++;
        cyc(); req_valid = '0; #1;
        total++; if (bus !== {1'b1, 3'd3, 1'b0, 1'b1, 8'hA5}) $display("FAIL wr_bus_c1 got=%b", bus); else pass_cnt++;
        for (int c = 2; c <= 3; c++) begin
            cyc(); #1;
            total++; if (bus !== {1'b0, 3'd3, 1'b0, 1'b1, 8'hA5} || rsp_valid !== 2'b00) $display("FAIL wr_strobe_c%0d got=%b rsp=%b", c, bus, rsp_valid); else pass_cnt++;
        end
        cyc(); #1;
        total++; if (bus !== {1'b1, 3'd3, 1'b0, 1'b1, 8'hA5}) $display("FAIL wr_bus_c4 got=%b", bus); else pass_cnt++;
        total++; if (rsp_valid !== 2'b01) $display("FAIL wr_rsp_c4 got=%b exp=01", rsp_valid); else pass_cnt++;
        cyc(); #1;
        total++; if (bus !== 14'b1_000_1_0_00000000 || rsp_valid !== 2'b00) $display("FAIL wr_idle_c5 got=%b rsp=%b", bus, rsp_valid); else pass_cnt++;
        idle(10);
    endtask

    task automatic test_read();
        cyc();
        req_valid = 2'b10; req_write = 2'b00; req_addr[5:3] = 3'd5; data_in = 8'h00;
        #1;
        total++; if (ready !== 2'b10) $display("FAIL rd_ready_c0 got=%b exp=10", ready); else pass_cnt++;
        cyc(); req_valid = '0; #1;
        total++; if (bus[13:8] !== {1'b1, 3'd5, 1'b1, 1'b0}) $display("FAIL rd_bus_c1 got=%b", bus[13:8]); else pass_cnt++;
        cyc(); data_in = 8'h3C; #1;
        total++; if (bus[13:8] !== {1'b0, 3'd5, 1'b1, 1'b0}) $display("FAIL rd_bus_c2 got=%b", bus[13:8]); else pass_cnt++;
        cyc(); #1;
        total++; if (bus[13:8] !== {1'b0, 3'd5, 1'b1, 1'b0}) $display("FAIL rd_bus_c3 got=%b", bus[13:8]); else pass_cnt++;
        cyc(); data_in = 8'h00; #1;
        total++; if (rsp_valid !== 2'b10) $display("FAIL rd_rsp_c4 got=%b exp=10", rsp_valid); else pass_cnt++;
        total++; if (rdata !== 8'h3C) $display("FAIL rd_rdata_c4 got=%h exp=3c", rdata); else pass_cnt++;
        total++; if (bus[13:8] !== {1'b1, 3'd5, 1'b1, 1'b0}) $display("FAIL rd_bus_c4 got=%b", bus[13:8]); else pass_cnt++;
        cyc(); #1;
        total++; if (bus[13:8] !== {1'b1, 3'd0, 1'b1, 1'b0} || rsp_valid !== 2'b00) $display("FAIL rd_idle_c5 got=%b rsp=%b", bus[13:8], rsp_valid); else pass_cnt++;
        idle(10);
    endtask

    task automatic test_back_to_back();
        int g_cyc[$], g_idx[$], g2_cyc[$];
        int lo[$], hi[$], lo2[$], hi2[$];
        int run = 0, run2 = 0;
        logic prev = 1'b1, prev2 = 1'b1, seen = 1'b0, seen2 = 1'b0;
        cyc();
        req_valid = 2'b11; req_write = 2'b11; req_addr = {3'd2, 3'd1}; req_wdata = 16'h2211;
        for (int c = 0; c < 48; c++) begin
            if (c > 0) cyc();
            #1;
            if (ready != '0) begin g_cyc.push_back(c); g_idx.push_back(ready[1] ? 1 : 0); end
            if (ready2 != '0) g2_cyc.push_back(c);
            if (cs_n == prev) run++;
            else begin
                if (!prev) lo.push_back(run); else if (seen) hi.push_back(run);
                if (!cs_n) seen = 1'b1;
                prev = cs_n; run = 1;
            end
            if (cs_n2 == prev2) run2++;
            else begin
                if (!prev2) lo2.push_back(run2); else if (seen2) hi2.push_back(run2);
                if (!cs_n2) seen2 = 1'b1;
                prev2 = cs_n2; run2 = 1;
            end
        end
        cyc(); req_valid = '0;
        total++; if (g_cyc.size() < 6 || g2_cyc.size() < 6 || lo.size() < 6 || hi.size() < 5 || lo2.size() < 5 || hi2.size() < 4)
            $display("FAIL b2b_counts got grants=%0d/%0d lo=%0d/%0d exp at least 6/6 6/5", g_cyc.size(), g2_cyc.size(), lo.size(), lo2.size());
        else begin
            pass_cnt++;
            for (int i = 0; i < 6; i++) begin
                total++; if (g_idx[i] !== i % 2) $display("FAIL b2b_order[%0d] got=%0d exp=%0d", i, g_idx[i], i % 2); else pass_cnt++;
                if (i > 0) begin
                    total++; if (g_cyc[i] - g_cyc[i-1] !== 5) $display("FAIL b2b_period[%0d] got=%0d exp=5", i, g_cyc[i] - g_cyc[i-1]); else pass_cnt++;
                    total++; if (g2_cyc[i] - g2_cyc[i-1] !== 7) $display("FAIL b2b_period2[%0d] got=%0d exp=7", i, g2_cyc[i] - g2_cyc[i-1]); else pass_cnt++;
                end
            end
            for (int i = 0; i < 5; i++) begin
                total++; if (lo[i] !== 2 || hi[i] !== 3) $display("FAIL b2b_cs_runs[%0d] got lo=%0d hi=%0d exp lo=2 hi=3", i, lo[i], hi[i]); else pass_cnt++;
                total++; if (lo2[i] !== 3) $display("FAIL b2b_cs2_low[%0d] got=%0d exp=3", i, lo2[i]); else pass_cnt++;
            end
            for (int i = 0; i < 4; i++) begin
                total++; if (hi2[i] !== 4) $display("FAIL b2b_cs2_high[%0d] got=%0d exp=4", i, hi2[i]); else pass_cnt++;
            end
        end
        idle(12);
    endtask

    task automatic test_reset_mid();
        int spurious = 0;
        cyc();
        req_valid = 2'b01; req_write = 2'b01; req_addr[2:0] = 3'd7; req_wdata[7:0] = 8'h5A;
        #1;
        total++; if (ready !== 2'b01) $display("FAIL rst_ready_c0 got=%b exp=01", ready); else pass_cnt++;
        cyc(); req_valid = '0;
        cyc(); #1;
        total++; if (cs_n !== 1'b0 || oe !== 1'b1) $display("FAIL rst_pre_strobe got cs=%b oe=%b exp cs=0 oe=1", cs_n, oe); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (cs_n !== 1'b1 || oe !== 1'b0 || cs_n2 !== 1'b1 || oe2 !== 1'b0) $display("FAIL rst_async got cs=%b oe=%b cs2=%b oe2=%b exp 1 0 1 0", cs_n, oe, cs_n2, oe2); else pass_cnt++;
        idle(2);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cyc(); #1;
            if (rsp_valid != '0 || !cs_n) spurious++;
        end
        total++; if (spurious !== 0) $display("FAIL rst_no_rsp got=%0d exp=0", spurious); else pass_cnt++;
        cyc(); req_valid = 2'b11; #1;
        total++; if (ready !== 2'b01) $display("FAIL rst_ptr_grant got=%b exp=01", ready); else pass_cnt++;
        cyc(); req_valid = '0;
        idle(12);
    endtask

    task automatic test_drop();
        cyc();
        req_valid = 2'b10; req_write = 2'b00; req_addr[5:3] = 3'd4; #1;
        total++; if (ready !== 2'b10) $display("FAIL drop_ready_c0 got=%b exp=10", ready); else pass_cnt++;
        cyc(); req_valid = 2'b01; #1;
        total++; if (ready !== 2'b00) $display("FAIL drop_ready_c1 got=%b exp=00", ready); else pass_cnt++;
        cyc(); req_valid = 2'b00; #1;
        total++; if (ready !== 2'b00) $display("FAIL drop_ready_c2 got=%b exp=00", ready); else pass_cnt++;
        cyc(); req_valid = 2'b10; #1;
        total++; if (ready !== 2'b00) $display("FAIL drop_ready_c3 got=%b exp=00", ready); else pass_cnt++;
        cyc(); #1;
        total++; if (ready !== 2'b00 || rsp_valid !== 2'b10) $display("FAIL drop_c4 got ready=%b rsp=%b exp 00 10", ready, rsp_valid); else pass_cnt++;
        cyc(); #1;
        total++; if (ready !== 2'b10) $display("FAIL drop_regrant_c5 got=%b exp=10", ready); else pass_cnt++;
        cyc(); req_valid = '0;
        idle(12);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_drop();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
